// File: rtl/proc_pkg.sv
// Shared processor types and widths used by the MAR and data-memory stage.
package proc_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Request payload captured when an access is accepted
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Control-unit <-> data-memory handshake bundle.
interface data_mem_ctrl_if;
    import proc_pkg::*;

    logic [ADDR_W-1:0] addr_in;
    logic              req;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output addr_in, req, we, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  addr_in, req, we, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port word array: synchronous write, read data valid in the enabled cycle.
module dmem_array
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data is captured by the controller's MDR register on the commit edge
    assign rdata = en ? mem[addr] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: one multi-cycle read/write per request with req/busy/done handshake.
module data_mem_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    mem_req_t          req_q;
    mem_req_t          req_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic              err_d;
    logic              in_range_c;
    logic              commit_c;
    logic              mem_we_c;

    assign in_range_c = (req_q.addr < ADDR_W'(DEPTH));
    assign commit_c   = (state == ACCESS) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = ACCESS;
            ACCESS:  if (cnt_q == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for counter, latched request and output registers
    always_comb begin
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    req_d.addr  = bus.addr_in;
                    req_d.we    = bus.we;
                    req_d.wdata = bus.wdata;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    busy_d      = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d = 1'b1;
                    err_d  = !in_range_c;
                    if (in_range_c) begin
                        if (req_q.we) mem_we_c = 1'b1;
                        else          rdata_d  = mem_rdata;
                    end
                end
            end
            DONE:    busy_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Write enable is gated by reset so an aborted write never lands
    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (commit_c && in_range_c),
        .we    (mem_we_c && rst_n),
        .addr  (req_q.addr[IDX_W-1:0]),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: three controllers with wait states 2, 0 and 4.
module tb_data_mem_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [23:0] addr_s  [3];
    logic        req_s   [3];
    logic        we_s    [3];
    logic [7:0]  wdata_s [3];
    logic [7:0]  rdata_s [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        err_s   [3];

    typedef struct {
        int         id;
        int         cyc;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus1 ();
    data_mem_ctrl_if bus2 ();

    data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.addr_in = addr_s[0];
    assign bus0.req     = req_s[0];
    assign bus0.we      = we_s[0];
    assign bus0.wdata   = wdata_s[0];
    assign bus1.addr_in = addr_s[1];
    assign bus1.req     = req_s[1];
    assign bus1.we      = we_s[1];
    assign bus1.wdata   = wdata_s[1];
    assign bus2.addr_in = addr_s[2];
    assign bus2.req     = req_s[2];
    assign bus2.we      = we_s[2];
    assign bus2.wdata   = wdata_s[2];

    assign rdata_s[0] = bus0.rdata;
    assign busy_s[0]  = bus0.busy;
    assign done_s[0]  = bus0.done;
    assign err_s[0]   = bus0.err;
    assign rdata_s[1] = bus1.rdata;
    assign busy_s[1]  = bus1.busy;
    assign done_s[1]  = bus1.done;
    assign err_s[1]   = bus1.err;
    assign rdata_s[2] = bus2.rdata;
    assign busy_s[2]  = bus2.busy;
    assign done_s[2]  = bus2.done;
    assign err_s[2]   = bus2.err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int id);
        return (id == 0) ? 2 : ((id == 1) ? 0 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: dut %0d got done with nothing outstanding (cycle %0d)", i, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_dut_id", 32'(i), 32'(e.id));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rdata", 32'(rdata_s[i]), 32'(e.rdata));
                    chk("err", 32'(err_s[i]), 32'(e.err));
                    chk("busy_in_done", 32'(busy_s[i]), 32'd1);
                end
            end
        end
    end

    // One complete transaction; returns just after the edge that ends the done cycle
    task automatic do_access(input int id, input logic [23:0] a, input logic w,
                             input logic [7:0] d, input logic [7:0] er, input logic ee,
                             input bit disturb);
        exp_t e;
        bit   seen;
        addr_s[id]  = a;
        we_s[id]    = w;
        wdata_s[id] = d;
        req_s[id]   = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_accept", 32'(busy_s[id]), 32'd1);
        e.id    = id;
        e.cyc   = cyc + wait_of(id) + 1;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        req_s[id] = 1'b0;
        if (disturb) begin
            addr_s[id]  = 24'd32;
            wdata_s[id] = 8'hFF;
            we_s[id]    = ~w;
            req_s[id]   = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_s[id] === 1'b1) seen = 1'b1;
            if (i == 1) req_s[id] = 1'b0;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: dut %0d got no done expected one", id);
        end
        @(posedge clk);
        #1;
    endtask

    // Accept an access on dut0, then hold reset for two edges before it can commit
    task automatic aborted_access(input logic [23:0] a, input logic w, input logic [7:0] d);
        int dcount;
        addr_s[0]  = a;
        we_s[0]    = w;
        wdata_s[0] = d;
        req_s[0]   = 1'b1;
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_rdata", 32'(rdata_s[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy_s[0]), 32'd0);
        chk("rst_mid_done", 32'(done_s[0]), 32'd0);
        chk("rst_mid_err", 32'(err_s[0]), 32'd0);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) dcount++;
        end
        chk("no_done_after_reset", 32'(dcount), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_s[i]  = '0;
            req_s[i]   = 1'b0;
            we_s[i]    = 1'b0;
            wdata_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_rdata", 32'(rdata_s[i]), 32'd0);
            chk("reset_busy", 32'(busy_s[i]), 32'd0);
            chk("reset_done", 32'(done_s[i]), 32'd0);
            chk("reset_err", 32'(err_s[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back on the 2-wait-state controller
        do_access(0, 24'd100, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
        do_access(0, 24'd100, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);
        do_access(0, 24'd44,  1'b1, 8'h77, 8'hA5, 1'b0, 1'b0);
        do_access(0, 24'd32,  1'b1, 8'h11, 8'hA5, 1'b0, 1'b0);

        // Inputs disturbed and req pulsed while busy
        do_access(0, 24'd5,   1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1);
        do_access(0, 24'd32,  1'b0, 8'h00, 8'h11, 1'b0, 1'b0);
        do_access(0, 24'd5,   1'b0, 8'h00, 8'h3C, 1'b0, 1'b0);

        // Out-of-range accesses flag err and touch nothing
        do_access(0, 24'd300, 1'b1, 8'hEE, 8'h3C, 1'b1, 1'b0);
        do_access(0, 24'd44,  1'b0, 8'h00, 8'h77, 1'b0, 1'b0);
        do_access(0, 24'd300, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0);

        // Reset during a read, then during a write
        aborted_access(24'd100, 1'b0, 8'h00);
        aborted_access(24'd100, 1'b1, 8'h5A);
        do_access(0, 24'd100, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);

        // Zero wait states
        do_access(1, 24'd0,   1'b1, 8'h12, 8'h00, 1'b0, 1'b0);
        do_access(1, 24'd255, 1'b1, 8'hED, 8'h00, 1'b0, 1'b0);
        do_access(1, 24'd0,   1'b0, 8'h00, 8'h12, 1'b0, 1'b0);
        do_access(1, 24'd255, 1'b0, 8'h00, 8'hED, 1'b0, 1'b0);

        // Four wait states
        do_access(2, 24'd0,   1'b1, 8'hC3, 8'h00, 1'b0, 1'b0);
        do_access(2, 24'd255, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0);
        do_access(2, 24'd0,   1'b0, 8'h00, 8'hC3, 1'b0, 1'b0);
        do_access(2, 24'd255, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
